// File: rtl/acs_butterfly.sv
// Radix-2 add-compare-select butterfly for a hard-decision Viterbi decoder.
// Handles frame initialisation, global MSB normalisation and metric saturation.
module acs_butterfly #(
    parameter int unsigned PM_W      = 8,
    parameter bit          IS_STATE0 = 1'b0,
    parameter int unsigned INIT_BIAS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            frame_start,
    input  logic            norm_in,
    input  logic [PM_W-1:0] pm_p0,
    input  logic [PM_W-1:0] pm_p1,
    input  logic [1:0]      bm_p0_0,
    input  logic [1:0]      bm_p1_0,
    input  logic [1:0]      bm_p0_1,
    input  logic [1:0]      bm_p1_1,
    output logic [PM_W-1:0] pm_s0,
    output logic [PM_W-1:0] pm_s1,
    output logic            dec_s0,
    output logic            dec_s1,
    output logic            msb_out,
    output logic            out_valid
);

    localparam logic [PM_W-1:0] BIAS    = PM_W'(INIT_BIAS);
    localparam logic [PM_W-1:0] E0_INIT = IS_STATE0 ? '0 : BIAS;

    // Add at PM_W+1 bits and clamp any carry-out to the all-ones metric.
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] e,
                                                 input logic [1:0]      bm);
        logic [PM_W:0] sum;
        sum = {1'b0, e} + {{(PM_W-1){1'b0}}, bm};
        return sum[PM_W] ? '1 : sum[PM_W-1:0];
    endfunction

    logic [PM_W-1:0] e0, e1;
    logic [PM_W-1:0] c00, c10, c01, c11;
    logic [PM_W-1:0] pm_s0_d, pm_s1_d;
    logic            dec_s0_d, dec_s1_d;

    logic [PM_W-1:0] pm_s0_q, pm_s1_q;
    logic            dec_s0_q, dec_s1_q;
    logic            valid_q;

    // Frame start overrides normalisation; clearing the MSB subtracts 2^(PM_W-1).
    always_comb begin
        e0 = pm_p0;
        e1 = pm_p1;
        if (frame_start) begin
            e0 = E0_INIT;
            e1 = BIAS;
        end else if (norm_in) begin
            e0 = {1'b0, pm_p0[PM_W-2:0]};
            e1 = {1'b0, pm_p1[PM_W-2:0]};
        end
    end

    assign c00 = sat_add(e0, bm_p0_0);
    assign c10 = sat_add(e1, bm_p1_0);
    assign c01 = sat_add(e0, bm_p0_1);
    assign c11 = sat_add(e1, bm_p1_1);

    // Strict compare: ties keep the p0 survivor.
    always_comb begin
        dec_s0_d = (c10 < c00);
        dec_s1_d = (c11 < c01);
        pm_s0_d  = dec_s0_d ? c10 : c00;
        pm_s1_d  = dec_s1_d ? c11 : c01;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pm_s0_q  <= '0;
            pm_s1_q  <= '0;
            dec_s0_q <= 1'b0;
            dec_s1_q <= 1'b0;
            valid_q  <= 1'b0;
        end else if (in_valid) begin
            pm_s0_q  <= pm_s0_d;
            pm_s1_q  <= pm_s1_d;
            dec_s0_q <= dec_s0_d;
            dec_s1_q <= dec_s1_d;
            valid_q  <= 1'b1;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign pm_s0     = pm_s0_q;
    assign pm_s1     = pm_s1_q;
    assign dec_s0    = dec_s0_q;
    assign dec_s1    = dec_s1_q;
    assign out_valid = valid_q;
    assign msb_out   = pm_s0_q[PM_W-1] & pm_s1_q[PM_W-1];

endmodule

// File: tb/tb_acs_butterfly.sv
// Self-checking bench for acs_butterfly: one instance with IS_STATE0=1 and one
// with IS_STATE0=0 share every input; both are compared against an integer model.
module tb_acs_butterfly;

    localparam int PM_W = 8;
    localparam int BIAS = 64;
    localparam int PMAX = 255;
    localparam int HALF = 128;

    logic       clk = 1'b0;
    logic       rst, in_valid, frame_start, norm_in;
    logic [7:0] pm_p0, pm_p1;
    logic [1:0] bm_p0_0, bm_p1_0, bm_p0_1, bm_p1_1;

    logic [7:0] a_pm_s0, a_pm_s1, b_pm_s0, b_pm_s1;
    logic       a_dec_s0, a_dec_s1, a_msb, a_ov;
    logic       b_dec_s0, b_dec_s1, b_msb, b_ov;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    acs_butterfly #(.PM_W(PM_W), .IS_STATE0(1'b1), .INIT_BIAS(BIAS)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .norm_in(norm_in), .pm_p0(pm_p0), .pm_p1(pm_p1),
        .bm_p0_0(bm_p0_0), .bm_p1_0(bm_p1_0), .bm_p0_1(bm_p0_1), .bm_p1_1(bm_p1_1),
        .pm_s0(a_pm_s0), .pm_s1(a_pm_s1), .dec_s0(a_dec_s0), .dec_s1(a_dec_s1),
        .msb_out(a_msb), .out_valid(a_ov)
    );

    acs_butterfly #(.PM_W(PM_W), .IS_STATE0(1'b0), .INIT_BIAS(BIAS)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .norm_in(norm_in), .pm_p0(pm_p0), .pm_p1(pm_p1),
        .bm_p0_0(bm_p0_0), .bm_p1_0(bm_p1_0), .bm_p0_1(bm_p0_1), .bm_p1_1(bm_p1_1),
        .pm_s0(b_pm_s0), .pm_s1(b_pm_s1), .dec_s0(b_dec_s0), .dec_s1(b_dec_s1),
        .msb_out(b_msb), .out_valid(b_ov)
    );

    typedef struct {
        int pm0;
        int d0;
        int pm1;
        int d1;
    } res_t;

    typedef struct {
        bit   fs;
        bit   nm;
        int   p0, p1;
        int   b00, b10, b01, b11;
        res_t ea;   // expected, IS_STATE0 = 1
        res_t eb;   // expected, IS_STATE0 = 0
    } vec_t;

    // Reference: one trellis step computed directly from the ACS rules.
    function automatic res_t ref_step(bit is0, bit fs, bit nm, int p0, int p1,
                                      int b00, int b10, int b01, int b11);
        res_t r;
        int e0, e1, c00, c10, c01, c11;
        if (fs) begin
            e0 = is0 ? 0 : BIAS;
            e1 = BIAS;
        end else if (nm) begin
            e0 = p0 % HALF;
            e1 = p1 % HALF;
        end else begin
            e0 = p0;
            e1 = p1;
        end
        c00 = (e0 + b00 > PMAX) ? PMAX : e0 + b00;
        c10 = (e1 + b10 > PMAX) ? PMAX : e1 + b10;
        c01 = (e0 + b01 > PMAX) ? PMAX : e0 + b01;
        c11 = (e1 + b11 > PMAX) ? PMAX : e1 + b11;
        r.d0  = (c10 < c00) ? 1 : 0;
        r.pm0 = (c10 < c00) ? c10 : c00;
        r.d1  = (c11 < c01) ? 1 : 0;
        r.pm1 = (c11 < c01) ? c11 : c01;
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input res_t ea, input res_t eb, input int ov);
        int msb_a, msb_b;
        msb_a = (ea.pm0 >= HALF && ea.pm1 >= HALF) ? 1 : 0;
        msb_b = (eb.pm0 >= HALF && eb.pm1 >= HALF) ? 1 : 0;
        chk({tag, " a.out_valid"}, int'(a_ov), ov);
        chk({tag, " a.pm_s0"}, int'(a_pm_s0), ea.pm0);
        chk({tag, " a.dec_s0"}, int'(a_dec_s0), ea.d0);
        chk({tag, " a.pm_s1"}, int'(a_pm_s1), ea.pm1);
        chk({tag, " a.dec_s1"}, int'(a_dec_s1), ea.d1);
        chk({tag, " a.msb_out"}, int'(a_msb), msb_a);
        chk({tag, " b.out_valid"}, int'(b_ov), ov);
        chk({tag, " b.pm_s0"}, int'(b_pm_s0), eb.pm0);
        chk({tag, " b.dec_s0"}, int'(b_dec_s0), eb.d0);
        chk({tag, " b.pm_s1"}, int'(b_pm_s1), eb.pm1);
        chk({tag, " b.dec_s1"}, int'(b_dec_s1), eb.d1);
        chk({tag, " b.msb_out"}, int'(b_msb), msb_b);
    endtask

    task automatic drive(input bit v, input bit fs, input bit nm, input int p0, input int p1,
                         input int b00, input int b10, input int b01, input int b11);
        in_valid    = v;
        frame_start = fs;
        norm_in     = nm;
        pm_p0       = 8'(p0);
        pm_p1       = 8'(p1);
        bm_p0_0     = 2'(b00);
        bm_p1_0     = 2'(b10);
        bm_p0_1     = 2'(b01);
        bm_p1_1     = 2'(b11);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];
    res_t zero_r, exp_a, exp_b;
    int   exp_ov;

    initial begin
        zero_r = '{pm0: 0, d0: 0, pm1: 0, d1: 0};

        // {fs, nm, p0, p1, b00, b10, b01, b11, expected a, expected b}
        vecs[0] = '{1, 0,   0,   0, 2, 0, 0, 2, '{2, 0, 0, 0},     '{64, 1, 64, 0}};
        vecs[1] = '{0, 1, 130, 200, 1, 1, 1, 1, '{3, 0, 3, 0},     '{3, 0, 3, 0}};
        vecs[2] = '{1, 1, 130, 200, 1, 1, 1, 1, '{1, 0, 1, 0},     '{65, 0, 65, 0}};
        vecs[3] = '{0, 0, 254, 255, 2, 1, 0, 0, '{255, 0, 254, 0}, '{255, 0, 254, 0}};
        vecs[4] = '{0, 0,  10,   5, 0, 2, 1, 0, '{7, 1, 5, 1},     '{7, 1, 5, 1}};
        vecs[5] = '{0, 1, 255, 128, 2, 2, 2, 2, '{2, 1, 2, 1},     '{2, 1, 2, 1}};
        vecs[6] = '{0, 0, 100, 100, 3, 3, 0, 3, '{103, 0, 100, 0}, '{103, 0, 100, 0}};
        vecs[7] = '{0, 0, 127, 200, 2, 0, 0, 0, '{129, 0, 127, 0}, '{129, 0, 127, 0}};

        // Reset held two cycles with in_valid asserted.
        rst = 1'b1;
        drive(1, 0, 0, 254, 255, 2, 1, 0, 0);
        tick();
        check_all("reset1", zero_r, zero_r, 0);
        tick();
        check_all("reset2", zero_r, zero_r, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(1, vecs[i].fs, vecs[i].nm, vecs[i].p0, vecs[i].p1,
                  vecs[i].b00, vecs[i].b10, vecs[i].b01, vecs[i].b11);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, 1);
        end

        // Mid-frame reset with in_valid high clears everything, including msb_out.
        drive(1, 0, 0, 254, 255, 2, 1, 0, 0);
        tick();
        check_all("pre_rst", '{255, 0, 254, 0}, '{255, 0, 254, 0}, 1);
        rst = 1'b1;
        tick();
        check_all("mid_rst", zero_r, zero_r, 0);
        rst = 1'b0;

        // frame_start without in_valid has no effect.
        drive(0, 1, 0, 0, 0, 2, 0, 0, 2);
        tick();
        check_all("fs_novalid", zero_r, zero_r, 0);

        // Three back-to-back steps, then four idle cycles holding the last result.
        exp_a = zero_r;
        exp_b = zero_r;
        for (int s = 0; s < 3; s++) begin
            drive(1, (s == 0), 0, 50 + 40 * s, 60 + 30 * s, s, 2 - s, 1, s);
            exp_a = ref_step(1'b1, (s == 0), 1'b0, 50 + 40 * s, 60 + 30 * s, s, 2 - s, 1, s);
            exp_b = ref_step(1'b0, (s == 0), 1'b0, 50 + 40 * s, 60 + 30 * s, s, 2 - s, 1, s);
            tick();
            check_all($sformatf("b2b%0d", s), exp_a, exp_b, 1);
        end
        for (int s = 0; s < 4; s++) begin
            drive(0, 0, 0, $urandom_range(255), $urandom_range(255), 1, 2, 0, 1);
            tick();
            check_all($sformatf("hold%0d", s), exp_a, exp_b, 0);
        end

        // Randomised steps against the model.
        exp_ov = 0;
        for (int n = 0; n < 10000; n++) begin
            bit v, fs, nm;
            int p0, p1, b00, b10, b01, b11;
            v   = ($urandom_range(9) != 0);
            fs  = ($urandom_range(99) == 0);
            nm  = ($urandom_range(9) == 0);
            p0  = (n % 7 == 0) ? 250 + $urandom_range(5) : $urandom_range(255);
            p1  = (n % 11 == 0) ? 250 + $urandom_range(5) : $urandom_range(255);
            b00 = $urandom_range(2);
            b10 = $urandom_range(2);
            b01 = $urandom_range(2);
            b11 = $urandom_range(2);
            drive(v, fs, nm, p0, p1, b00, b10, b01, b11);
            if (v) begin
                exp_a  = ref_step(1'b1, fs, nm, p0, p1, b00, b10, b01, b11);
                exp_b  = ref_step(1'b0, fs, nm, p0, p1, b00, b10, b01, b11);
                exp_ov = 1;
            end else begin
                exp_ov = 0;
            end
            tick();
            check_all("rand", exp_a, exp_b, exp_ov);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acs_butterfly.md
# acs_butterfly

Add-compare-select butterfly for the hard-decision Viterbi decoder, one stage downstream of the per-state branch metric computation. Each instance owns one radix-2 butterfly:
- predecessor states p0 = 2j and p1 = 2j+1;
- successor states s0 = j and s1 = j + 2^(K-2).

Each valid step it adds the 2-bit branch metrics to the predecessor path metrics, selects the survivor per successor and registers the new path metrics and decision bits. It also handles frame initialisation, global normalisation and saturation. The path metric bank and traceback memory consume its outputs.

## Interface
- PM_W, 8: path metric width in bits (minimum 4).
- IS_STATE0, 0: 1 only for the butterfly whose p0 is trellis state 0 (governs frame init).
- INIT_BIAS, 64: metric loaded into every non-zero state at frame start; must be < 2^(PM_W-1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  step strobe: branch metrics and predecessor metrics valid this cycle.
- frame_start  in  1  qualifies in_valid; first trellis step of a frame.
- norm_in  in  1  global flag: every path metric in the bank had its MSB set at the previous step.
- pm_p0, pm_p1  in  PM_W  current path metrics of p0 and p1.
- bm_p0_0, bm_p1_0  in  2  branch metrics p0→s0 and p1→s0 (value 0..2).
- bm_p0_1, bm_p1_1  in  2  branch metrics p0→s1 and p1→s1 (value 0..2).
- pm_s0, pm_s1  out  PM_W  registered new path metrics of s0 and s1.
- dec_s0, dec_s1  out  1  survivor decision: 0 = from p0, 1 = from p1.
- msb_out  out  1  pm_s0[PM_W-1] & pm_s1[PM_W-1]; the bank ANDs this across butterflies to form norm_in.
- out_valid  out  1  registered in_valid; marks a new decision pair.

## Operation
Per-cycle behaviour:
- If in_valid = 0: all registers hold. out_valid goes 0 next cycle. Inputs are ignored.

Effective predecessor metrics e0 and e1 on an in_valid step:
- If frame_start = 1:
  - e0 = 0 when IS_STATE0 = 1, else e0 = INIT_BIAS.
  - e1 = INIT_BIAS.
  - pm_p0, pm_p1 and norm_in are ignored.
- Else if norm_in = 1: e0 = pm_p0 with MSB cleared, e1 = pm_p1 with MSB cleared. This subtracts 2^(PM_W-1) from every state uniformly.
- Else: e0 = pm_p0, e1 = pm_p1.

Candidate metrics:
- Computed at PM_W+1 bits: c00 = e0 + bm_p0_0, c10 = e1 + bm_p1_0, c01 = e0 + bm_p0_1, c11 = e1 + bm_p1_1.
- Each candidate saturates to 2^PM_W - 1 when its sum exceeds that value.

Compare/select for s0:
- dec_s0 = 1 iff c10 < c00 (strict).
- pm_s0 = min(c00, c10).
- Ties select p0, so dec_s0 = 0.

s1 uses the identical rule on c01 and c11.

Branch metric value 3 is illegal. Behaviour for bm = 3 is to add 3 arithmetically; no checking is performed.

msb_out is derived combinationally from the pm_s0/pm_s1 registers.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N with in_valid = 1 appear on pm_s*, dec_s* and out_valid after edge N. out_valid is high for exactly that cycle per step.
- Throughput: one step per cycle; back-to-back in_valid is supported.
- Reset: with rst = 1 at an edge:
  - pm_s0 = pm_s1 = 0, dec_s0 = dec_s1 = 0, out_valid = 0, msb_out = 0.
  - rst takes priority over in_valid.
  - A reset mid-frame discards the frame. The next frame requires frame_start.
- frame_start with in_valid = 0 has no effect.
- frame_start and norm_in both high: frame_start wins and norm_in is ignored.
- Saturation and normalisation in the same step: normalisation is applied first, then the addition, then saturation.
- The critical path is adder → comparator → mux. No internal pipeline stage.

## Test plan
All scenarios use PM_W = 8 and INIT_BIAS = 64.
- **Reset:** hold rst for 2 cycles with in_valid = 1 → pm_s0 = pm_s1 = 0, dec = 0, out_valid = 0 and msb_out = 0 throughout; first valid step after release gives out_valid = 1 exactly one cycle later.
- **Frame init, IS_STATE0 = 1:** frame_start = 1 with bm_p0_0 = 2, bm_p1_0 = 0, bm_p0_1 = 0, bm_p1_1 = 2 → pm_s0 = 2, dec_s0 = 0; pm_s1 = 0, dec_s1 = 0. With IS_STATE0 = 0 and the same bms → pm_s0 = 64, dec_s0 = 1; pm_s1 = 64, dec_s1 = 0.
- **Normalisation:** norm_in = 1, pm_p0 = 130, pm_p1 = 200, all bm = 1 → pm_s0 = pm_s1 = 3, dec = 0, msb_out = 0. Same inputs with frame_start = 1 (IS_STATE0 = 1) → frame init results, norm ignored.
- **Saturation and tie:** pm_p0 = 254, pm_p1 = 255, bm_p0_0 = 2, bm_p1_0 = 1 → both candidates 255, pm_s0 = 255, dec_s0 = 0, msb_out = 1 when s1 is also ≥ 128.
- **Hold / back-to-back:** three consecutive valid steps, then in_valid = 0 for 4 cycles → outputs update on each of the three steps, then hold the last values; out_valid pattern is 1,1,1,0,0,0,0.
- **Random reference check:** 10k random steps (bm values 0..2, ~10% norm_in, ~1% frame_start) → every output matches a behavioural model.
